// File: rtl/id_pkg.sv
// Shared definitions for the decode stage: opcodes, instruction field positions
// and the ID/EX bundle handed to execute.
package id_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 16;
  localparam int REG_W = 4;
  localparam int IMM_W = 22;
  localparam int OP_W  = 5;

  localparam logic [OP_W-1:0] OP_NOP    = 5'b00000;
  localparam logic [OP_W-1:0] OP_LOAD   = 5'b00100;
  localparam logic [OP_W-1:0] OP_STORE  = 5'b00101;
  localparam logic [OP_W-1:0] OP_BRANCH = 5'b01100;

  localparam int OPCODE_MSB   = 31;
  localparam int OPCODE_LSB   = 27;
  localparam int IMM_FLAG_BIT = 26;
  localparam int RD_MSB       = 25;
  localparam int RD_LSB       = 22;
  localparam int RS1_MSB      = 21;
  localparam int RS1_LSB      = 18;
  localparam int RS2_MSB      = 17;
  localparam int RS2_LSB      = 14;
  localparam int IMM_MSB      = IMM_W - 1;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [OP_W-1:0]  opcode;
    logic             imm_flag;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  rs1_val;
    logic [XLEN-1:0]  rs2_val;
    logic [XLEN-1:0]  imm;
    logic             writes_rd;
    logic             is_load;
  } id_ex_t;

  function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/id_regfile.sv
// 16x32 register file: two combinational read ports with write-through bypass,
// one synchronous write port; r0 is hardwired to zero.
module id_regfile
  import id_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  output logic [XLEN-1:0]  rs1_val,
  output logic [XLEN-1:0]  rs2_val,
  input  logic             wb_en,
  input  logic [REG_W-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_data
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en && wb_rd != '0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Same-cycle write-back wins over the stored value so decode never sees stale data.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != '0) rs1_val = (wb_en && wb_rd == rs1) ? wb_data : regs[rs1];
    if (rs2 != '0) rs2_val = (wb_en && wb_rd == rs2) ? wb_data : regs[rs2];
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID latch, field decode, register read, registered ID/EX bundle.
// Two edges from fetch presentation to id_valid; a load-use hazard holds fetch for one cycle.
module id_stage
  import id_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [XLEN-1:0]  if_instruction,
  input  logic [XLEN-1:0]  if_pc,
  input  logic             is_branch_taken,
  input  logic             wb_en,
  input  logic [REG_W-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic             hold_pc,
  output logic             id_valid,
  output logic [XLEN-1:0]  id_pc,
  output logic [OP_W-1:0]  id_opcode,
  output logic             id_imm_flag,
  output logic [REG_W-1:0] id_rd,
  output logic [XLEN-1:0]  id_rs1_val,
  output logic [XLEN-1:0]  id_rs2_val,
  output logic [XLEN-1:0]  id_imm,
  output logic             id_writes_rd,
  output logic             id_is_load
);

  logic            ifid_valid;
  logic [XLEN-1:0] ifid_instr;
  logic [XLEN-1:0] ifid_pc;
  id_ex_t          id_ex_q;
  id_ex_t          decoded;

  logic [OP_W-1:0]  opcode;
  logic             imm_flag;
  logic [REG_W-1:0] rd;
  logic [REG_W-1:0] rs1_f;
  logic [REG_W-1:0] rs2_f;
  logic [REG_W-1:0] rs1_idx;
  logic [REG_W-1:0] rs2_idx;
  logic [XLEN-1:0]  rs1_val;
  logic [XLEN-1:0]  rs2_val;
  logic             has_src;
  logic             stall;

  assign opcode   = ifid_instr[OPCODE_MSB:OPCODE_LSB];
  assign imm_flag = ifid_instr[IMM_FLAG_BIT];
  assign rd       = ifid_instr[RD_MSB:RD_LSB];
  assign rs1_f    = ifid_instr[RS1_MSB:RS1_LSB];
  assign rs2_f    = ifid_instr[RS2_MSB:RS2_LSB];
  assign has_src  = !imm_flag && opcode != OP_NOP;

  // Instructions without sources read r0 so their operand values come out as zero.
  assign rs1_idx = has_src ? rs1_f : '0;
  assign rs2_idx = has_src ? rs2_f : '0;

  id_regfile u_regfile (
    .clock   (clock),
    .reset   (reset),
    .rs1     (rs1_idx),
    .rs2     (rs2_idx),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .wb_en   (wb_en),
    .wb_rd   (wb_rd),
    .wb_data (wb_data)
  );

  always_comb begin
    decoded           = '0;
    decoded.valid     = 1'b1;
    decoded.pc        = ifid_pc;
    decoded.opcode    = opcode;
    decoded.imm_flag  = imm_flag;
    decoded.rd        = rd;
    decoded.rs1_val   = rs1_val;
    decoded.rs2_val   = rs2_val;
    decoded.imm       = imm_flag ? sext_imm(ifid_instr[IMM_MSB:0]) : '0;
    decoded.writes_rd = !(opcode == OP_NOP || opcode == OP_STORE ||
                          opcode == OP_BRANCH || rd == '0);
    decoded.is_load   = (opcode == OP_LOAD);
  end

  assign stall = ifid_valid && has_src && id_ex_q.valid && id_ex_q.is_load &&
                 id_ex_q.rd != '0 && (id_ex_q.rd == rs1_f || id_ex_q.rd == rs2_f);

  // A taken branch discards the dependent instruction, so fetch need not hold.
  assign hold_pc = stall && !is_branch_taken;

  always_ff @(posedge clock) begin
    if (reset) begin
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      ifid_pc    <= '0;
      id_ex_q    <= '0;
    end else if (is_branch_taken) begin
      ifid_valid <= 1'b0;
      id_ex_q    <= '0;
    end else if (stall) begin
      id_ex_q    <= '0;
    end else begin
      ifid_valid <= 1'b1;
      ifid_instr <= if_instruction;
      ifid_pc    <= if_pc;
      id_ex_q    <= ifid_valid ? decoded : '0;
    end
  end

  assign id_valid     = id_ex_q.valid;
  assign id_pc        = id_ex_q.pc;
  assign id_opcode    = id_ex_q.opcode;
  assign id_imm_flag  = id_ex_q.imm_flag;
  assign id_rd        = id_ex_q.rd;
  assign id_rs1_val   = id_ex_q.rs1_val;
  assign id_rs2_val   = id_ex_q.rs2_val;
  assign id_imm       = id_ex_q.imm;
  assign id_writes_rd = id_ex_q.writes_rd;
  assign id_is_load   = id_ex_q.is_load;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a behavioural pipeline model.
module tb_id_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic        is_branch_taken;
  logic        wb_en;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        hold_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_opcode;
  logic        id_imm_flag;
  logic [3:0]  id_rd;
  logic [31:0] id_rs1_val;
  logic [31:0] id_rs2_val;
  logic [31:0] id_imm;
  logic        id_writes_rd;
  logic        id_is_load;

  id_stage dut (
    .clock           (clock),
    .reset           (reset),
    .if_instruction  (if_instruction),
    .if_pc           (if_pc),
    .is_branch_taken (is_branch_taken),
    .wb_en           (wb_en),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .hold_pc         (hold_pc),
    .id_valid        (id_valid),
    .id_pc           (id_pc),
    .id_opcode       (id_opcode),
    .id_imm_flag     (id_imm_flag),
    .id_rd           (id_rd),
    .id_rs1_val      (id_rs1_val),
    .id_rs2_val      (id_rs2_val),
    .id_imm          (id_imm),
    .id_writes_rd    (id_writes_rd),
    .id_is_load      (id_is_load)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] valid, pc, opcode, imm_flag, rd, rs1, rs2, imm, writes, is_load;
  } exp_t;

  logic [31:0] m_regs [16];
  logic        m_if_v;
  logic [31:0] m_if_i;
  logic [31:0] m_if_pc;
  exp_t        m_ex;
  logic        m_hold;
  logic        last_hold;

  function automatic logic [31:0] m_read(input int r);
    if (r == 0) return 32'h0;
    if (wb_en && int'(wb_rd) == r) return wb_data;
    return m_regs[r];
  endfunction

  function automatic exp_t m_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    int op, rd, r1, r2, imm22;
    logic immf, src;
    op    = int'(ins >> 27);
    immf  = ins[26];
    rd    = int'((ins >> 22) & 32'hF);
    r1    = int'((ins >> 18) & 32'hF);
    r2    = int'((ins >> 14) & 32'hF);
    imm22 = int'(ins & 32'h3F_FFFF);
    src   = !immf && op != 0;
    e          = '0;
    e.valid    = 1;
    e.pc       = pc;
    e.opcode   = op;
    e.imm_flag = {31'b0, immf};
    e.rd       = rd;
    e.rs1      = src ? m_read(r1) : 32'h0;
    e.rs2      = src ? m_read(r2) : 32'h0;
    if (immf) e.imm = (imm22 >= 32'h20_0000) ? imm22 - 32'h40_0000 : imm22;
    e.writes   = (op == 0 || op == 5 || op == 12 || rd == 0) ? 0 : 1;
    e.is_load  = (op == 4) ? 1 : 0;
    return e;
  endfunction

  function automatic logic m_stall();
    int op, r1, r2;
    op = int'(m_if_i >> 27);
    r1 = int'((m_if_i >> 18) & 32'hF);
    r2 = int'((m_if_i >> 14) & 32'hF);
    return m_if_v && !m_if_i[26] && op != 0 && m_ex.valid == 1 && m_ex.is_load == 1 &&
           m_ex.rd != 0 && (m_ex.rd == r1 || m_ex.rd == r2);
  endfunction

  task automatic m_clock();
    exp_t nxt;
    logic st;
    if (reset) begin
      m_if_v = 0;
      m_if_i = 0;
      m_if_pc = 0;
      m_ex = '0;
      for (int i = 0; i < 16; i++) m_regs[i] = 0;
    end else begin
      st  = m_stall();
      nxt = m_if_v ? m_decode(m_if_i, m_if_pc) : exp_t'('0);
      if (is_branch_taken) begin
        m_if_v = 0;
        m_ex = '0;
      end else if (st) begin
        m_ex = '0;
      end else begin
        m_ex = nxt;
        m_if_v = 1;
        m_if_i = if_instruction;
        m_if_pc = if_pc;
      end
      if (wb_en && wb_rd != 0) m_regs[wb_rd] = wb_data;
    end
  endtask

  task automatic compare_all();
    m_hold = m_stall() && !is_branch_taken;
    chk("hold_pc",   {31'b0, hold_pc},      {31'b0, m_hold});
    chk("valid",     {31'b0, id_valid},     m_ex.valid);
    chk("pc",        id_pc,                 m_ex.pc);
    chk("opcode",    {27'b0, id_opcode},    m_ex.opcode);
    chk("imm_flag",  {31'b0, id_imm_flag},  m_ex.imm_flag);
    chk("rd",        {28'b0, id_rd},        m_ex.rd);
    chk("rs1_val",   id_rs1_val,            m_ex.rs1);
    chk("rs2_val",   id_rs2_val,            m_ex.rs2);
    chk("imm",       id_imm,                m_ex.imm);
    chk("writes_rd", {31'b0, id_writes_rd}, m_ex.writes);
    chk("is_load",   {31'b0, id_is_load},   m_ex.is_load);
  endtask

  // One clock: drive inputs, check at negedge, advance the model with the DUT edge.
  task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic br,
                      input logic wen, input logic [3:0] wrd, input logic [31:0] wdat,
                      input logic rst);
    reset = rst;
    if_instruction = ins;
    if_pc = pc;
    is_branch_taken = br;
    wb_en = wen;
    wb_rd = wrd;
    wb_data = wdat;
    @(negedge clock);
    compare_all();
    last_hold = hold_pc;
    @(posedge clock);
    m_clock();
    #1;
  endtask

  function automatic logic [31:0] rand_ins();
    logic [4:0]  op;
    logic        immf;
    logic [3:0]  rd, r1, r2;
    logic [21:0] imm;
    case ($urandom % 5)
      0: op = 5'd0;
      1: op = 5'd4;
      2: op = 5'd5;
      3: op = 5'd12;
      default: op = 5'($urandom);
    endcase
    immf = ($urandom % 4) == 0;
    rd   = 4'($urandom % 6);
    r1   = 4'($urandom % 6);
    r2   = 4'($urandom % 6);
    imm  = 22'($urandom);
    return immf ? {op, 1'b1, rd, imm} : {op, 1'b0, rd, r1, r2, imm[13:0]};
  endfunction

  localparam logic [31:0] NOP  = 32'h0;
  localparam logic [31:0] X_R2 = {5'b01001, 1'b0, 4'd3, 4'd0, 4'd2, 14'd0};
  localparam logic [31:0] IMM1 = {5'b00010, 1'b1, 4'd1, 22'h3F_FFFF};
  localparam logic [31:0] IMM2 = {5'b00010, 1'b1, 4'd2, 22'd10};
  localparam logic [31:0] LD4  = {5'b00100, 1'b0, 4'd4, 4'd1, 4'd0, 14'd0};
  localparam logic [31:0] USE4 = {5'b01001, 1'b0, 4'd5, 4'd4, 4'd0, 14'd0};
  localparam logic [31:0] USE5 = {5'b01001, 1'b0, 4'd6, 4'd5, 4'd0, 14'd0};
  localparam logic [31:0] USE0 = {5'b01001, 1'b0, 4'd7, 4'd0, 4'd0, 14'd0};

  initial begin
    logic [31:0] cur_ins, cur_pc;
    logic        br, wen, rst;

    reset = 1'b1;
    if_instruction = $urandom;
    if_pc = $urandom;
    is_branch_taken = 1'($urandom);
    wb_en = 1'($urandom);
    wb_rd = 4'($urandom);
    wb_data = $urandom;
    @(posedge clock);
    m_clock();
    #1;

    // Reset with random inputs keeps everything at zero.
    for (int i = 0; i < 2; i++) begin
      step($urandom, $urandom, 1'($urandom), 1'($urandom), 4'($urandom), $urandom, 1'b1);
      chk("rst_valid", {31'b0, id_valid}, 32'd0);
      chk("rst_hold", {31'b0, last_hold}, 32'd0);
    end

    // First instruction after reset (also writes r2=10) issues two edges later.
    step(NOP, 32'h100, 0, 1, 4'd2, 32'd10, 0);
    chk("first_valid_1edge", {31'b0, id_valid}, 32'd0);
    step(X_R2, 32'h200, 0, 0, 4'd0, 32'd0, 0);
    chk("first_valid_2edge", {31'b0, id_valid}, 32'd1);
    chk("first_pc", id_pc, 32'h100);
    step(NOP, 32'h204, 0, 0, 4'd0, 32'd0, 0);
    chk("x_rd", {28'b0, id_rd}, 32'd3);
    chk("x_rs2", id_rs2_val, 32'd10);
    chk("x_rs1", id_rs1_val, 32'd0);
    chk("x_writes", {31'b0, id_writes_rd}, 32'd1);

    // Immediates: all-ones sign-extends, small positive stays positive.
    step(IMM1, 32'h210, 0, 0, 4'd0, 32'd0, 0);
    step(IMM2, 32'h214, 0, 0, 4'd0, 32'd0, 0);
    chk("imm_neg", id_imm, 32'hFFFF_FFFF);
    step(NOP, 32'h218, 0, 0, 4'd0, 32'd0, 0);
    chk("imm_pos", id_imm, 32'd10);
    chk("imm_flag", {31'b0, id_imm_flag}, 32'd1);

    // Load-use: one hold cycle, one bubble, then the dependent op issues.
    step(LD4, 32'h300, 0, 0, 4'd0, 32'd0, 0);
    step(USE4, 32'h304, 0, 0, 4'd0, 32'd0, 0);
    chk("lu_load_issued", {31'b0, id_is_load}, 32'd1);
    step(NOP, 32'h308, 0, 0, 4'd0, 32'd0, 0);
    chk("lu_hold", {31'b0, last_hold}, 32'd1);
    chk("lu_bubble", {31'b0, id_valid}, 32'd0);
    step(NOP, 32'h308, 0, 0, 4'd0, 32'd0, 0);
    chk("lu_hold_released", {31'b0, last_hold}, 32'd0);
    chk("lu_dep_valid", {31'b0, id_valid}, 32'd1);
    chk("lu_dep_pc", id_pc, 32'h304);
    step(NOP, 32'h30C, 0, 0, 4'd0, 32'd0, 0);

    // Branch during a stall: no hold, both stages bubble, target issues normally.
    step(LD4, 32'h400, 0, 0, 4'd0, 32'd0, 0);
    step(USE4, 32'h404, 0, 0, 4'd0, 32'd0, 0);
    step(NOP, 32'h408, 1, 0, 4'd0, 32'd0, 0);
    chk("br_hold", {31'b0, last_hold}, 32'd0);
    chk("br_bubble1", {31'b0, id_valid}, 32'd0);
    step(NOP, 32'h500, 0, 0, 4'd0, 32'd0, 0);
    chk("br_bubble2", {31'b0, id_valid}, 32'd0);
    step(NOP, 32'h504, 0, 0, 4'd0, 32'd0, 0);
    chk("br_target_valid", {31'b0, id_valid}, 32'd1);
    chk("br_target_pc", id_pc, 32'h500);

    // Same-cycle write-back bypass, and r0 stays zero.
    step(USE5, 32'h600, 0, 0, 4'd0, 32'd0, 0);
    step(NOP, 32'h604, 0, 1, 4'd5, 32'hDEAD, 0);
    chk("bypass_r5", id_rs1_val, 32'hDEAD);
    step(USE0, 32'h700, 0, 0, 4'd0, 32'd0, 0);
    step(NOP, 32'h704, 0, 1, 4'd0, 32'h1234, 0);
    chk("r0_bypass", id_rs1_val, 32'd0);
    step(USE0, 32'h708, 0, 0, 4'd0, 32'd0, 0);
    step(NOP, 32'h70C, 0, 0, 4'd0, 32'd0, 0);
    chk("r0_after_wb", id_rs1_val, 32'd0);

    // Randomized traffic; fetch honours hold_pc and redirects on a taken branch.
    cur_ins = rand_ins();
    cur_pc = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      br  = ($urandom % 10) == 0;
      wen = 1'($urandom);
      rst = ($urandom % 250) == 0;
      step(cur_ins, cur_pc, br, wen, 4'($urandom), $urandom, rst);
      if (!(m_hold && !rst)) begin
        cur_ins = rand_ins();
        cur_pc = br ? ($urandom & 32'hFFFF_FFFC) : cur_pc + 4;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
